// File: rtl/freq_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : freq_div_pkg
// Description : Shared helper for the freq_div counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package freq_div_pkg;

    // Smallest counter width able to hold 0 .. n-1 (never below one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage : freq_div_pkg
`default_nettype wire

// File: rtl/freq_div_mod_n_counter.sv
`default_nettype none
// ============================================================================
// Module      : mod_n_counter
// Description : Modulo-N up counter with sync reset, next-value and wrap strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module mod_n_counter
    import freq_div_pkg::*;
#(
    parameter int unsigned N = 5,
    parameter int unsigned W = cnt_width(N)
) (
    input  logic         clk,
    input  logic         rst,
    output logic [W-1:0] cnt_nxt,
    output logic         wrap
);

    localparam logic [W-1:0] C_LAST = W'(N - 1);

    logic [W-1:0] r_cnt;

    always_comb begin
        wrap    = (r_cnt == C_LAST);
        cnt_nxt = wrap ? '0 : r_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= cnt_nxt;
        end
    end

endmodule : mod_n_counter
`default_nettype wire

// File: rtl/freq_div.sv
`default_nettype none
// ============================================================================
// Module      : freq_div
// Description : Integer clock-rate divider producing div-N and div-2N waveforms.
// Revision    : 1.0 - initial release
// ============================================================================
module freq_div
    import freq_div_pkg::*;
#(
    parameter int unsigned DIV_N = 5,
    parameter int unsigned CNT_W = cnt_width(DIV_N)
) (
    input  logic clk_in,
    input  logic rst,
    output logic div5,
    output logic div10
);

    localparam logic [CNT_W-1:0] C_HALF = CNT_W'(DIV_N / 2);

    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_wrap;

    mod_n_counter #(
        .N (DIV_N),
        .W (CNT_W)
    ) u_cnt (
        .clk     (clk_in),
        .rst     (rst),
        .cnt_nxt (w_cnt_nxt),
        .wrap    (w_wrap)
    );

    // Compare against the next count so div5 rises on the same edge the counter wraps.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            div5  <= 1'b0;
            div10 <= 1'b0;
        end else begin
            div5 <= (w_cnt_nxt < C_HALF);
            if (w_wrap) begin
                div10 <= ~div10;
            end
        end
    end

endmodule : freq_div
`default_nettype wire

// File: tb/tb_freq_div.sv
`default_nettype none
// ============================================================================
// Module      : tb_freq_div
// Description : Directed self-checking bench for freq_div at DIV_N = 5, 2, 8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_freq_div;

    logic clk;
    logic rst;
    logic d5_div5, d5_div10;
    logic d2_div5, d2_div10;
    logic d8_div5, d8_div10;

    int n_checks = 0;
    int n_fails  = 0;

    freq_div #(.DIV_N(5)) u_dut5 (.clk_in(clk), .rst(rst), .div5(d5_div5), .div10(d5_div10));
    freq_div #(.DIV_N(2)) u_dut2 (.clk_in(clk), .rst(rst), .div5(d2_div5), .div10(d2_div10));
    freq_div #(.DIV_N(8)) u_dut8 (.clk_in(clk), .rst(rst), .div5(d8_div5), .div10(d8_div10));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s : got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected levels k edges after reset release, from the counter value k mod n.
    function automatic int exp_div5(input int n, input int k);
        return ((k % n) < (n / 2)) ? 1 : 0;
    endfunction

    function automatic int exp_div10(input int n, input int k);
        return ((k / n) % 2);
    endfunction

    task automatic check_all(input int k);
        check_value($sformatf("n5_div5_k%0d", k),  int'(d5_div5),  exp_div5(5, k));
        check_value($sformatf("n5_div10_k%0d", k), int'(d5_div10), exp_div10(5, k));
        check_value($sformatf("n2_div5_k%0d", k),  int'(d2_div5),  exp_div5(2, k));
        check_value($sformatf("n2_div10_k%0d", k), int'(d2_div10), exp_div10(2, k));
        check_value($sformatf("n8_div5_k%0d", k),  int'(d8_div5),  exp_div5(8, k));
        check_value($sformatf("n8_div10_k%0d", k), int'(d8_div10), exp_div10(8, k));
    endtask

    task automatic check_zero(input string tag);
        check_value({tag, "_n5_div5"},  int'(d5_div5),  0);
        check_value({tag, "_n5_div10"}, int'(d5_div10), 0);
        check_value({tag, "_n2_div5"},  int'(d2_div5),  0);
        check_value({tag, "_n2_div10"}, int'(d2_div10), 0);
        check_value({tag, "_n8_div5"},  int'(d8_div5),  0);
        check_value({tag, "_n8_div10"}, int'(d8_div10), 0);
    endtask

    // Hand-derived DIV_N=5 waveform for edges 1..10 after reset release.
    int tbl_div5  [10] = '{1, 0, 0, 0, 1, 1, 0, 0, 0, 1};
    int tbl_div10 [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 0};

    initial begin
        int k;
        int prev5, prev10, rises5, rises10;

        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_zero($sformatf("rst_init%0d", i));
        end

        rst = 1'b0;
        for (k = 1; k <= 10; k++) begin
            step();
            check_value($sformatf("tbl_div5_k%0d", k),  int'(d5_div5),  tbl_div5[k-1]);
            check_value($sformatf("tbl_div10_k%0d", k), int'(d5_div10), tbl_div10[k-1]);
            check_all(k);
        end
        for (k = 11; k <= 50; k++) begin
            step();
            check_all(k);
        end

        // Reset hold from a running (arbitrary) phase.
        for (k = 51; k <= 53; k++) begin
            step();
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_zero($sformatf("rst_hold%0d", i));
        end
        rst = 1'b0;
        for (k = 1; k <= 6; k++) begin
            step();
            check_all(k);
        end

        // One-cycle reset landing on edge 7, mid-period.
        rst = 1'b1;
        step();
        check_zero("rst_mid");
        rst = 1'b0;
        for (k = 1; k <= 10; k++) begin
            step();
            check_all(k);
        end

        // Long run from a div10 period boundary: exact rise counts, every edge checked.
        prev5   = int'(d5_div5);
        prev10  = int'(d5_div10);
        rises5  = 0;
        rises10 = 0;
        for (k = 11; k <= 10010; k++) begin
            step();
            check_value("long_div5",  int'(d5_div5),  exp_div5(5, k));
            check_value("long_div10", int'(d5_div10), exp_div10(5, k));
            if (d5_div5 && prev5 == 0)   rises5++;
            if (d5_div10 && prev10 == 0) rises10++;
            prev5  = int'(d5_div5);
            prev10 = int'(d5_div10);
        end
        check_value("long_div5_rises",  rises5,  2000);
        check_value("long_div10_rises", rises10, 1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_freq_div
`default_nettype wire

// File: doc/freq_div.md
Name: freq_div

Overview:
- Integer clock-rate divider driven by a single system clock `clk_in`.
- Produces two registered enable-style square waves:
  - `div5`: one period every DIV_N input clocks.
  - `div10`: one period every 2*DIV_N input clocks, 50% duty.
- Used as the low-rate timebase for the vending controller and similar blocks.
- No clock muxing or negedge logic; all flops are on the `clk_in` rising edge.

Parameters:
- DIV_N, 5: base division ratio; integer, 2 to 65535.
  - `div5` has period DIV_N clocks.
  - `div10` has period 2*DIV_N clocks.
- CNT_W, $clog2(DIV_N): counter width. Derived; do not override.

Ports:
- clk_in, input, 1: system clock; all logic on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- div5, output, 1: divide-by-DIV_N waveform, registered.
- div10, output, 1: divide-by-2*DIV_N waveform, 50% duty, registered.

Behaviour:
- Internal counter `cnt` is CNT_W bits, modulo DIV_N.
  - Next value: cnt_nxt = (cnt == DIV_N-1) ? 0 : cnt+1.
  - Updated every rising edge while rst=0.
- Reset:
  - On a rising edge with rst=1: cnt=0, div5=0, div10=0.
  - Reset asserted mid-operation clears all state on that edge regardless of phase.
  - Counting resumes on the first edge with rst=0.
- div5:
  - Registered update: div5 <= (cnt_nxt < DIV_N/2), using integer floor.
  - Steady state: high while cnt is in 0 .. floor(DIV_N/2)-1, low otherwise.
  - For DIV_N=5: high 2 clocks, low 3 clocks (40% duty).
  - Odd DIV_N gives sub-50% duty by design.
- div10:
  - Toggles on every edge where cnt wraps from DIV_N-1 to 0.
  - Result: period 2*DIV_N, exactly 50% duty.
- Phase alignment: div5 rising edges coincide with the cnt wrap edge, which is also every div10 toggle.
- Timing after reset release (DIV_N=5, edges numbered from the first edge with rst=0):
  - Edge 1: cnt=1, div5=1.
  - Edge 2: div5=0.
  - Edge 5: cnt=0, div5=1, div10=1.
  - Edge 10: div10=0.
- Outputs come directly from flops: no combinational path from rst or cnt to the outputs.
- Counter wrap never exceeds DIV_N-1; illegal cnt values are unreachable.

Decomposition:
- No shared package is required; DIV_N is a local parameter.
- One natural sub-module, `mod_n_counter`:
  - Parameterized modulo-DIV_N counter with sync reset.
  - Outputs `cnt_nxt` and a `wrap` strobe.
- `freq_div` instantiates `mod_n_counter` and adds the div5 compare flop and the div10 toggle flop.

Test Plan:
- Reset hold: rst=1 for 3 edges with arbitrary prior state -> div5=0, div10=0, cnt=0 after the first reset edge.
- Steady state, DIV_N=5: release reset, run 50 edges -> div5 pattern 1,0,0,0,1,1,0,0,0,1,1,... from edge 1; rises every 5 edges, high 2 of 5.
- div10 check, DIV_N=5: toggles exactly at edges 5, 10, 15, ...; high 5 and low 5 clocks; each rise coincides with a div5 rise.
- Mid-operation reset: assert rst at edge 7 for 1 cycle -> both outputs 0 on that edge; sequence restarts as from a fresh reset, with div5=1 one edge after release.
- Parameter sweep, DIV_N=2 and DIV_N=8:
  - DIV_N=2: div5 toggles every clock (50%); div10 period 4.
  - DIV_N=8: div5 high 4 of 8; div10 period 16, 50%.
- Long run, 10000 edges, DIV_N=5: count div5 rising edges = 2000 and div10 rising edges = 1000, with no glitches.
